// File: rtl/apb_arbiter.sv
// Round-robin arbiter placing NUM_REQ requesters onto a single APB master port,
// with an ACCESS wait-state timeout and one-cycle completion pulses per requester.
module apb_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                          PCLK,
    input  logic                          PRESETn,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_slverr,
    output logic                          PSEL,
    output logic                          PENABLE,
    output logic                          PWRITE,
    output logic [ADDR_WIDTH-1:0]         PADDR,
    output logic [DATA_WIDTH-1:0]         PWDATA,
    input  logic [DATA_WIDTH-1:0]         PRDATA,
    input  logic                          PREADY,
    input  logic                          PSLVERR
);
    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned WAIT_W = 8;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t              state;
    logic [IDX_W-1:0]    last_grant;
    logic [WAIT_W-1:0]   wait_cnt;

    logic                grant_found;
    logic [IDX_W-1:0]    grant_idx;
    logic                sel_write;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    // Round-robin search starting one past the previous owner.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            if (!grant_found && req_valid[IDX_W'((32'(last_grant) + i) % NUM_REQ)]) begin
                grant_found = 1'b1;
                grant_idx   = IDX_W'((32'(last_grant) + i) % NUM_REQ);
            end
        end
    end

    // Payload mux for the winning requester.
    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == grant_idx) begin
                sel_write = req_write[i];
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (PRESETn && state == IDLE && grant_found) begin
            req_ready = NUM_REQ'(1) << grant_idx;
        end
    end

    // last_grant doubles as the owner of the in-flight transfer.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state      <= IDLE;
            last_grant <= IDX_W'(NUM_REQ - 1);
            wait_cnt   <= '0;
            PSEL       <= 1'b0;
            PENABLE    <= 1'b0;
            PWRITE     <= 1'b0;
            PADDR      <= '0;
            PWDATA     <= '0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
            rsp_slverr <= 1'b0;
        end else begin
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        state      <= SETUP;
                        last_grant <= grant_idx;
                        PSEL       <= 1'b1;
                        PENABLE    <= 1'b0;
                        PWRITE     <= sel_write;
                        PADDR      <= sel_addr;
                        PWDATA     <= sel_wdata;
                    end
                end
                SETUP: begin
                    state    <= ACCESS;
                    PENABLE  <= 1'b1;
                    wait_cnt <= '0;
                end
                ACCESS: begin
                    if (PREADY) begin
                        state      <= IDLE;
                        PSEL       <= 1'b0;
                        PENABLE    <= 1'b0;
                        rsp_valid  <= NUM_REQ'(1) << last_grant;
                        rsp_rdata  <= PWRITE ? '0 : PRDATA;
                        rsp_slverr <= PSLVERR;
                    end else if (wait_cnt == WAIT_LAST) begin
                        // Timeout abort: PREADY in this same cycle wins above.
                        state      <= IDLE;
                        PSEL       <= 1'b0;
                        PENABLE    <= 1'b0;
                        rsp_valid  <= NUM_REQ'(1) << last_grant;
                        rsp_rdata  <= '0;
                        rsp_slverr <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    PSEL    <= 1'b0;
                    PENABLE <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_apb_arbiter.sv
// Directed self-checking bench for apb_arbiter (4 requesters, TIMEOUT=16).
module tb_apb_arbiter;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned NR = 4;
    localparam int unsigned TO = 16;

    logic             PCLK = 1'b0;
    logic             PRESETn;
    logic [NR-1:0]    req_valid, req_ready, req_write, rsp_valid;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [DW-1:0]    rsp_rdata, PRDATA, PWDATA;
    logic [AW-1:0]    PADDR;
    logic             rsp_slverr, PSEL, PENABLE, PWRITE, PREADY, PSLVERR;

    int n_tests = 0;
    int n_fail  = 0;

    apb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic tick();
        @(negedge PCLK);
    endtask

    task automatic do_reset();
        tick();
        PRESETn = 1'b0;
        req_valid = '0;
        tick();
        tick();
        PRESETn = 1'b1;
    endtask

    task automatic test_reset();
        PRESETn = 1'b0;
        tick();
        tick();
        #1;
        n_tests++;
        if ({PSEL, PENABLE, PWRITE, rsp_slverr} !== 4'b0000) begin
            n_fail++; $display("FAIL rst_ctrl: psel/pen/pwrite/slverr=%b expected 0000", {PSEL, PENABLE, PWRITE, rsp_slverr});
        end
        n_tests++;
        if (PADDR !== 32'h0 || PWDATA !== 32'h0 || rsp_rdata !== 32'h0) begin
            n_fail++; $display("FAIL rst_data: paddr=%h pwdata=%h rdata=%h expected all 0", PADDR, PWDATA, rsp_rdata);
        end
        n_tests++;
        if (rsp_valid !== 4'b0000 || req_ready !== 4'b0000) begin
            n_fail++; $display("FAIL rst_hs: rsp_valid=%b req_ready=%b expected 0000/0000", rsp_valid, req_ready);
        end
        PRESETn = 1'b1;
    endtask

    task automatic test_single_read();
        tick();
        req_valid = 4'b0100; req_write = '0; req_addr[2*AW +: AW] = 32'h10;
        PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = 32'hDEADBEEF;
        #1;
        n_tests++;
        if (req_ready !== 4'b0100) begin
            n_fail++; $display("FAIL sr_grant: req_ready=%b expected 0100", req_ready);
        end
        tick(); req_valid = '0; #1;
        n_tests++;
        if ({PSEL, PENABLE, PWRITE} !== 3'b100 || PADDR !== 32'h10) begin
            n_fail++; $display("FAIL sr_setup: sel/en/wr=%b paddr=%h expected 100/00000010", {PSEL, PENABLE, PWRITE}, PADDR);
        end
        tick(); #1;
        n_tests++;
        if ({PSEL, PENABLE} !== 2'b11 || rsp_valid !== 4'b0000) begin
            n_fail++; $display("FAIL sr_access: sel/en=%b rsp_valid=%b expected 11/0000", {PSEL, PENABLE}, rsp_valid);
        end
        tick(); #1;
        n_tests++;
        if ({PSEL, PENABLE} !== 2'b00 || rsp_valid !== 4'b0100) begin
            n_fail++; $display("FAIL sr_pulse: sel/en=%b rsp_valid=%b expected 00/0100", {PSEL, PENABLE}, rsp_valid);
        end
        n_tests++;
        if (rsp_rdata !== 32'hDEADBEEF || rsp_slverr !== 1'b0) begin
            n_fail++; $display("FAIL sr_rdata: rdata=%h slverr=%b expected deadbeef/0", rsp_rdata, rsp_slverr);
        end
        tick(); #1;
        n_tests++;
        if (rsp_valid !== 4'b0000 || rsp_rdata !== 32'hDEADBEEF || PADDR !== 32'h10) begin
            n_fail++; $display("FAIL sr_hold: rsp_valid=%b rdata=%h paddr=%h expected 0000/deadbeef/00000010", rsp_valid, rsp_rdata, PADDR);
        end
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] exp_rdy [13];
        logic [NR-1:0] exp_rsp [13];
        exp_rdy = '{4'h1, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0, 4'h1};
        exp_rsp = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 4'h8};
        do_reset();
        PRDATA = 32'hCAFEF00D; PREADY = 1'b1; req_write = '0; req_valid = 4'hF;
        for (int c = 0; c < 13; c++) begin
            if (c > 0) tick();
            #1;
            n_tests++;
            if (req_ready !== exp_rdy[c] || rsp_valid !== exp_rsp[c]) begin
                n_fail++; $display("FAIL rr_cycle%0d: req_ready=%b rsp_valid=%b expected %b/%b", c, req_ready, rsp_valid, exp_rdy[c], exp_rsp[c]);
            end
        end
        tick(); req_valid = '0;
        tick();
        tick();
    endtask

    task automatic test_timeout();
        tick();
        req_valid = 4'b0010; req_write = '0; req_addr[1*AW +: AW] = 32'h20; PREADY = 1'b0; PRDATA = 32'h55AA55AA;
        #1;
        n_tests++;
        if (req_ready !== 4'b0010) begin
            n_fail++; $display("FAIL to_grant: req_ready=%b expected 0010", req_ready);
        end
        tick(); req_valid = '0;
        for (int k = 1; k <= 16; k++) begin
            tick(); #1;
            n_tests++;
            if ({PSEL, PENABLE} !== 2'b11 || rsp_valid !== 4'b0000) begin
                n_fail++; $display("FAIL to_wait%0d: sel/en=%b rsp_valid=%b expected 11/0000", k, {PSEL, PENABLE}, rsp_valid);
            end
        end
        tick(); #1;
        n_tests++;
        if ({PSEL, PENABLE} !== 2'b00 || rsp_valid !== 4'b0010 || rsp_slverr !== 1'b1 || rsp_rdata !== 32'h0) begin
            n_fail++; $display("FAIL to_abort: sel/en=%b rsp_valid=%b slverr=%b rdata=%h expected 00/0010/1/00000000",
                {PSEL, PENABLE}, rsp_valid, rsp_slverr, rsp_rdata);
        end
    endtask

    task automatic test_timeout_pready();
        tick();
        req_valid = 4'b0101; req_write = '0; req_addr[2*AW +: AW] = 32'h30; PREADY = 1'b0; PRDATA = 32'h0BADF00D;
        #1;
        n_tests++;
        if (req_ready !== 4'b0100) begin
            n_fail++; $display("FAIL tp_grant: req_ready=%b expected 0100", req_ready);
        end
        tick(); req_valid = '0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 16) PREADY = 1'b1;
            #1;
            n_tests++;
            if ({PSEL, PENABLE} !== 2'b11 || rsp_valid !== 4'b0000) begin
                n_fail++; $display("FAIL tp_wait%0d: sel/en=%b rsp_valid=%b expected 11/0000", k, {PSEL, PENABLE}, rsp_valid);
            end
        end
        tick(); #1;
        n_tests++;
        if (rsp_valid !== 4'b0100 || rsp_slverr !== 1'b0 || rsp_rdata !== 32'h0BADF00D) begin
            n_fail++; $display("FAIL tp_done: rsp_valid=%b slverr=%b rdata=%h expected 0100/0/0badf00d", rsp_valid, rsp_slverr, rsp_rdata);
        end
    endtask

    task automatic test_wait_states();
        tick();
        req_valid = 4'b1010; req_write = 4'b1000; req_addr[3*AW +: AW] = 32'hA0;
        req_wdata[3*DW +: DW] = 32'h12345678; PREADY = 1'b0; PRDATA = 32'hFFFFFFFF;
        #1;
        n_tests++;
        if (req_ready !== 4'b1000) begin
            n_fail++; $display("FAIL ws_grant: req_ready=%b expected 1000", req_ready);
        end
        tick();
        req_valid = '0; req_write = '0; req_addr[3*AW +: AW] = 32'hBAD; req_wdata[3*DW +: DW] = 32'h0;
        #1;
        n_tests++;
        if ({PSEL, PENABLE, PWRITE} !== 3'b101 || PADDR !== 32'hA0 || PWDATA !== 32'h12345678) begin
            n_fail++; $display("FAIL ws_setup: sel/en/wr=%b paddr=%h pwdata=%h expected 101/000000a0/12345678", {PSEL, PENABLE, PWRITE}, PADDR, PWDATA);
        end
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 6) PREADY = 1'b1;
            #1;
            n_tests++;
            if ({PSEL, PENABLE, PWRITE, rsp_valid} !== 7'b111_0000 || PADDR !== 32'hA0 || PWDATA !== 32'h12345678) begin
                n_fail++; $display("FAIL ws_access%0d: sel/en/wr/rsp=%b paddr=%h pwdata=%h expected 1110000/000000a0/12345678",
                    k, {PSEL, PENABLE, PWRITE, rsp_valid}, PADDR, PWDATA);
            end
        end
        tick(); #1;
        n_tests++;
        if ({PSEL, PENABLE} !== 2'b00 || rsp_valid !== 4'b1000 || rsp_rdata !== 32'h0 || rsp_slverr !== 1'b0) begin
            n_fail++; $display("FAIL ws_done: sel/en=%b rsp_valid=%b rdata=%h slverr=%b expected 00/1000/00000000/0",
                {PSEL, PENABLE}, rsp_valid, rsp_rdata, rsp_slverr);
        end
        tick(); #1;
        n_tests++;
        if (rsp_valid !== 4'b0000 || PADDR !== 32'hA0 || PWDATA !== 32'h12345678 || PWRITE !== 1'b1) begin
            n_fail++; $display("FAIL ws_idle_hold: rsp_valid=%b paddr=%h pwdata=%h pwrite=%b expected 0000/000000a0/12345678/1",
                rsp_valid, PADDR, PWDATA, PWRITE);
        end
    endtask

    task automatic test_slverr();
        tick();
        req_valid = 4'b0001; req_write = '0; req_addr[0 +: AW] = 32'h40;
        PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'h11112222;
        #1;
        n_tests++;
        if (req_ready !== 4'b0001) begin
            n_fail++; $display("FAIL se_grant: req_ready=%b expected 0001", req_ready);
        end
        tick(); req_valid = '0;
        tick();
        tick(); #1;
        n_tests++;
        if (rsp_valid !== 4'b0001 || rsp_slverr !== 1'b1 || rsp_rdata !== 32'h11112222) begin
            n_fail++; $display("FAIL se_pulse: rsp_valid=%b slverr=%b rdata=%h expected 0001/1/11112222", rsp_valid, rsp_slverr, rsp_rdata);
        end
        tick(); PSLVERR = 1'b0; #1;
        n_tests++;
        if (rsp_valid !== 4'b0000 || rsp_slverr !== 1'b1) begin
            n_fail++; $display("FAIL se_hold: rsp_valid=%b slverr=%b expected 0000/1", rsp_valid, rsp_slverr);
        end
    endtask

    task automatic test_reset_in_access();
        tick();
        req_valid = 4'b0100; req_write = '0; req_addr[2*AW +: AW] = 32'h50; PREADY = 1'b0;
        #1;
        n_tests++;
        if (req_ready !== 4'b0100) begin
            n_fail++; $display("FAIL ra_grant: req_ready=%b expected 0100", req_ready);
        end
        tick(); req_valid = '0;
        tick(); #1;
        n_tests++;
        if ({PSEL, PENABLE} !== 2'b11) begin
            n_fail++; $display("FAIL ra_access: sel/en=%b expected 11", {PSEL, PENABLE});
        end
        PRESETn = 1'b0;
        tick(); PRESETn = 1'b1; #1;
        n_tests++;
        if ({PSEL, PENABLE} !== 2'b00 || rsp_valid !== 4'b0000 || PADDR !== 32'h0) begin
            n_fail++; $display("FAIL ra_reset: sel/en=%b rsp_valid=%b paddr=%h expected 00/0000/00000000", {PSEL, PENABLE}, rsp_valid, PADDR);
        end
        tick();
        req_valid = 4'hF; PREADY = 1'b1; PRDATA = 32'h77778888;
        #1;
        n_tests++;
        if (rsp_valid !== 4'b0000 || req_ready !== 4'b0001) begin
            n_fail++; $display("FAIL ra_regrant: rsp_valid=%b req_ready=%b expected 0000/0001", rsp_valid, req_ready);
        end
        tick(); req_valid = '0;
        tick();
        tick(); #1;
        n_tests++;
        if (rsp_valid !== 4'b0001 || rsp_rdata !== 32'h77778888) begin
            n_fail++; $display("FAIL ra_done: rsp_valid=%b rdata=%h expected 0001/77778888", rsp_valid, rsp_rdata);
        end
    endtask

    initial begin
        PRESETn = 1'b0; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_timeout();
        test_timeout_pready();
        test_wait_states();
        test_slverr();
        test_reset_in_access();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1, "watchdog");
    end
endmodule
